// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, IF/ID latch, redirect/stall/halt control
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC,
    input  logic [31:0] Instruction_Code,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    state_t      state;
    logic        is_system;
    logic [31:0] pc_seq;
    logic [31:0] pc_redirect;
    logic [31:0] count_inc;

    assign is_system   = (Instruction_Code == ECALL_WORD) || (Instruction_Code == EBREAK_WORD);
    assign pc_seq      = PC + 32'd4;
    assign pc_redirect = {redirect_target[31:2], 2'b00};
    // Counter sticks at all-ones rather than wrapping back to zero
    assign count_inc   = (fetch_count == 32'hFFFF_FFFF) ? fetch_count : fetch_count + 32'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= BOOT;
            PC          <= RESET_PC;
            if_id_pc    <= 32'h0000_0000;
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
            misalign    <= 1'b0;
            fetch_count <= 32'h0000_0000;
        end else begin
            misalign <= 1'b0;
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN, HALT: begin
                    if (redirect) begin
                        state       <= RUN;
                        PC          <= pc_redirect;
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_WORD;
                        halted      <= 1'b0;
                        misalign    <= |redirect_target[1:0];
                    end else if (state == RUN && !stall) begin
                        // The system word itself is kept valid in IF/ID while fetch freezes
                        if_id_instr <= Instruction_Code;
                        if_id_pc    <= PC;
                        if_id_valid <= 1'b1;
                        PC          <= pc_seq;
                        fetch_count <= count_inc;
                        if (is_system) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule
